// File: rtl/multicycle_mem_pkg.sv
// Shared encodings and helpers for the multicycle memory unit.
// Size codes, FSM states and the byte-lane enable function.
package multicycle_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int CNT_W  = 4;
  localparam int MAX_BE = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A word access covers every lane of the data word.
  function automatic logic [MAX_BE-1:0] byte_en(
    input logic [1:0]  sz,
    input int unsigned off,
    input int unsigned nbytes
  );
    logic [MAX_BE-1:0] m;
    m = '0;
    case (sz)
      SZ_BYTE: m = MAX_BE'(1) << off;
      SZ_HALF: m = MAX_BE'(3) << off;
      SZ_WORD: m = ~(MAX_BE'(0)) >> (MAX_BE - nbytes);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with per-byte write enables.
// Registered read returns the contents before a same-cycle write.
module mem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < DATA_W/8; b++) begin
        if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/multicycle_mem.sv
// Multicycle load/store unit: IDLE -> BUSY x LATENCY -> DONE.
// Loads fill mdr (and ir on fetch); stores write byte lanes.
module multicycle_mem
  import multicycle_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 9,
  parameter int LATENCY    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              i_or_d,
  input  logic              ir_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int AW    = DEPTH_LOG2;
  localparam int LA_W  = AW + OFF_W;

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;

  logic              wr_q, rej_q, uns_q, irw_q;
  logic [1:0]        sz_q;
  logic [LA_W-1:0]   addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req, bad;
  logic [DATA_W-1:0] sel_addr;
  logic [OFF_W-1:0]  sel_off, off_q;
  logic              unused_hi;

  logic              last, ram_en;
  logic [BYTES-1:0]  ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0] sh, load_val;

  assign req      = mem_read | mem_write;
  assign sel_addr = i_or_d ? alu_out : pc;
  assign sel_off  = sel_addr[OFF_W-1:0];
  assign off_q    = addr_q[OFF_W-1:0];
  assign unused_hi = ^sel_addr[DATA_W-1:LA_W];

  // Rejected accesses still run the full FSM, just without touching the RAM.
  assign bad = (mem_read & mem_write)
             | (size == SZ_RSVD)
             | ((size == SZ_HALF) & sel_off[0])
             | ((size == SZ_WORD) & (|sel_off));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (req) state_nx = ST_BUSY;
      ST_BUSY: if (cnt == '0) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != ST_IDLE);
    ready  = (state == ST_DONE);
    err    = ready & rej_q;
    last   = (state == ST_BUSY) & (cnt == '0);
    ram_en = last & ~rej_q;
    ram_we = (ram_en & wr_q)
           ? BYTES'(byte_en(sz_q, 32'(off_q), BYTES))
           : '0;
  end

  always_comb begin
    case (sz_q)
      SZ_BYTE: ram_wdata = {BYTES{wdata_q[7:0]}};
      SZ_HALF: ram_wdata = {(BYTES/2){wdata_q[15:0]}};
      default: ram_wdata = wdata_q;
    endcase
  end

  assign sh = ram_rdata >> {off_q, 3'b000};

  always_comb begin
    case (sz_q)
      SZ_BYTE: load_val = uns_q ? DATA_W'(sh[7:0])
                                : {{(DATA_W-8){sh[7]}}, sh[7:0]};
      SZ_HALF: load_val = uns_q ? DATA_W'(sh[15:0])
                                : {{(DATA_W-16){sh[15]}}, sh[15:0]};
      default: load_val = sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      wr_q    <= 1'b0;
      rej_q   <= 1'b0;
      uns_q   <= 1'b0;
      irw_q   <= 1'b0;
      sz_q    <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr     <= '0;
      ir      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (req) begin
          cnt     <= CNT_W'(LATENCY - 1);
          wr_q    <= mem_write;
          rej_q   <= bad;
          uns_q   <= load_unsigned;
          irw_q   <= ir_write;
          sz_q    <= size;
          addr_q  <= sel_addr[LA_W-1:0];
          wdata_q <= wdata;
        end
        ST_BUSY: if (cnt != '0) cnt <= cnt - 1'b1;
        ST_DONE: if (!rej_q && !wr_q) begin
          mdr <= load_val;
          if (irw_q) ir <= load_val;
        end
        default: ;
      endcase
    end
  end

  mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (addr_q[LA_W-1:OFF_W]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_multicycle_mem.sv
// Scoreboard bench for multicycle_mem at LATENCY 1 and 4.
// Expected results are queued at request time, popped at ready.
module tb_multicycle_mem;

  logic        clk = 1'b0;
  logic [1:0]  rst_n, mem_read, mem_write, i_or_d, ir_write;
  logic [1:0]  load_unsigned, ready, err, busy;
  logic [1:0]  size [2];
  logic [31:0] pc [2], alu_out [2], wdata [2], ir [2], mdr [2];

  typedef struct {
    logic [31:0] mdr;
    logic [31:0] ir;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sbq [$];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multicycle_mem #(.LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .i_or_d(i_or_d[0]), .ir_write(ir_write[0]),
    .size(size[0]), .load_unsigned(load_unsigned[0]),
    .pc(pc[0]), .alu_out(alu_out[0]), .wdata(wdata[0]),
    .ir(ir[0]), .mdr(mdr[0]),
    .ready(ready[0]), .err(err[0]), .busy(busy[0])
  );

  multicycle_mem #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .i_or_d(i_or_d[1]), .ir_write(ir_write[1]),
    .size(size[1]), .load_unsigned(load_unsigned[1]),
    .pc(pc[1]), .alu_out(alu_out[1]), .wdata(wdata[1]),
    .ir(ir[1]), .mdr(mdr[1]),
    .ready(ready[1]), .err(err[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle_inputs(input int k);
    mem_read[k] = 1'b0; mem_write[k] = 1'b0;
    i_or_d[k] = 1'b0; ir_write[k] = 1'b0;
    size[k] = 2'b00; load_unsigned[k] = 1'b0;
    pc[k] = 32'h0; alu_out[k] = 32'h0; wdata[k] = 32'h0;
  endtask

  task automatic check_reset(input int k);
    chk($sformatf("rst_ir%0d", k), ir[k], 32'h0);
    chk($sformatf("rst_mdr%0d", k), mdr[k], 32'h0);
    chk($sformatf("rst_flags%0d", k),
        {29'h0, ready[k], err[k], busy[k]}, 32'h0);
  endtask

  task automatic access(input string tag, input int k,
                        input logic rd, input logic wr,
                        input logic iod, input logic irw,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] e_mdr, input logic [31:0] e_ir,
                        input logic e_err, input int e_lat);
    exp_t e;
    int n;
    @(negedge clk);
    mem_read[k] = rd; mem_write[k] = wr;
    i_or_d[k] = iod; ir_write[k] = irw;
    size[k] = sz; load_unsigned[k] = uns;
    pc[k] = iod ? ~addr : addr;
    alu_out[k] = iod ? addr : ~addr;
    wdata[k] = wd;
    sbq.push_back('{e_mdr, e_ir, e_err, e_lat});
    @(negedge clk);
    idle_inputs(k);
    n = 1;
    while (!ready[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sbq.pop_front();
    chk({tag, "_lat"}, n, e.lat);
    chk({tag, "_err"}, {31'h0, err[k]}, {31'h0, e.err});
    chk({tag, "_busy"}, {31'h0, busy[k]}, 32'h1);
    @(negedge clk);
    chk({tag, "_rdy_pulse"}, {30'h0, ready[k], busy[k]}, 32'h0);
    chk({tag, "_mdr"}, mdr[k], e.mdr);
    chk({tag, "_ir"}, ir[k], e.ir);
  endtask

  initial begin
    rst_n = 2'b00;
    idle_inputs(0);
    idle_inputs(1);
    #12;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst_n = 2'b11;

    // LATENCY=1: word round trip and byte lanes
    access("st_w", 0, 0, 1, 1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF,
           32'h0, 32'h0, 0, 2);
    access("ld_w", 0, 1, 0, 1, 0, 2'b10, 0, 32'h10, 32'h0,
           32'hDEADBEEF, 32'h0, 0, 2);
    access("st_b", 0, 0, 1, 1, 0, 2'b00, 0, 32'h12, 32'h5A,
           32'hDEADBEEF, 32'h0, 0, 2);
    access("ld_bu", 0, 1, 0, 1, 0, 2'b00, 1, 32'h12, 32'h0,
           32'h5A, 32'h0, 0, 2);
    access("ld_bs", 0, 1, 0, 1, 0, 2'b00, 0, 32'h12, 32'h0,
           32'h5A, 32'h0, 0, 2);
    access("ld_w2", 0, 1, 0, 1, 0, 2'b10, 0, 32'h10, 32'h0,
           32'hDE5ABEEF, 32'h0, 0, 2);
    access("ld_bs13", 0, 1, 0, 1, 0, 2'b00, 0, 32'h13, 32'h0,
           32'hFFFFFFDE, 32'h0, 0, 2);
    access("ld_hs", 0, 1, 0, 1, 0, 2'b01, 0, 32'h12, 32'h0,
           32'hFFFFDE5A, 32'h0, 0, 2);
    access("ld_hu", 0, 1, 0, 1, 0, 2'b01, 1, 32'h10, 32'h0,
           32'h0000BEEF, 32'h0, 0, 2);

    // Instruction fetch through pc
    access("st_ins", 0, 0, 1, 1, 0, 2'b10, 0, 32'h20, 32'h8C220004,
           32'hFFFFBEEF & 32'h0000BEEF, 32'h0, 0, 2);
    access("fetch", 0, 1, 0, 0, 1, 2'b10, 0, 32'h20, 32'h0,
           32'h8C220004, 32'h8C220004, 0, 2);
    access("st_ins2", 0, 0, 1, 1, 0, 2'b10, 0, 32'h20, 32'h12345678,
           32'h8C220004, 32'h8C220004, 0, 2);
    access("fetch_nir", 0, 1, 0, 0, 0, 2'b10, 0, 32'h20, 32'h0,
           32'h12345678, 32'h8C220004, 0, 2);

    // Rejected accesses: nothing changes
    access("e_wmis", 0, 1, 0, 1, 1, 2'b10, 0, 32'h02, 32'h0,
           32'h12345678, 32'h8C220004, 1, 2);
    access("e_hmis", 0, 1, 0, 1, 1, 2'b01, 0, 32'h01, 32'h0,
           32'h12345678, 32'h8C220004, 1, 2);
    access("e_sz11", 0, 1, 0, 1, 1, 2'b11, 0, 32'h10, 32'h0,
           32'h12345678, 32'h8C220004, 1, 2);
    access("e_rw", 0, 1, 1, 1, 1, 2'b10, 0, 32'h10, 32'h0,
           32'h12345678, 32'h8C220004, 1, 2);
    access("e_stmis", 0, 0, 1, 1, 0, 2'b10, 0, 32'h12, 32'hFFFFFFFF,
           32'h12345678, 32'h8C220004, 1, 2);
    access("e_after", 0, 1, 0, 1, 0, 2'b10, 0, 32'h10, 32'h0,
           32'hDE5ABEEF, 32'h8C220004, 0, 2);

    // LATENCY=4 with reset abort and wraparound
    access("l4_st", 1, 0, 1, 1, 0, 2'b10, 0, 32'h10, 32'h22222222,
           32'h0, 32'h0, 0, 5);
    access("l4_ld", 1, 1, 0, 1, 0, 2'b10, 0, 32'h10, 32'h0,
           32'h22222222, 32'h0, 0, 5);

    @(negedge clk);
    mem_write[1] = 1'b1; i_or_d[1] = 1'b1; size[1] = 2'b10;
    alu_out[1] = 32'h10; wdata[1] = 32'h11111111;
    @(negedge clk);
    idle_inputs(1);
    chk("abort_busy1", {31'h0, busy[1]}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check_reset(1);
    @(negedge clk);
    check_reset(1);
    rst_n[1] = 1'b1;

    access("l4_kept", 1, 1, 0, 1, 0, 2'b10, 0, 32'h10, 32'h0,
           32'h22222222, 32'h0, 0, 5);
    access("l4_wrap", 1, 1, 0, 1, 0, 2'b10, 0, 32'h810, 32'h0,
           32'h22222222, 32'h0, 0, 5);
    access("l4_wst", 1, 0, 1, 1, 0, 2'b10, 0, 32'h810, 32'h33333333,
           32'h22222222, 32'h0, 0, 5);
    access("l4_wld", 1, 1, 0, 1, 0, 2'b10, 0, 32'h10, 32'h0,
           32'h33333333, 32'h0, 0, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_mem.md
MULTICYCLE_MEM -- requirements
Module: multicycle_mem

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as the data word width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL take parameter DEPTH_LOG2, default 9, as log2 of the number of words in the array.
REQ-003 The block SHALL take parameter LATENCY, default 1, range 1..15, as the number of BUSY cycles per access.
REQ-004 The block SHALL provide port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL provide ports mem_read and mem_write, inputs, 1 bit each: access requests, sampled only in IDLE.
REQ-007 The block SHALL provide port i_or_d, input, 1 bit: address select, 0 = pc, 1 = alu_out.
REQ-008 The block SHALL provide port ir_write, input, 1 bit: when set, the read result also loads ir.
REQ-009 The block SHALL provide port size, input, 2 bits: 00 byte, 01 half, 10 word; 11 is reserved.
REQ-010 The block SHALL provide port load_unsigned, input, 1 bit: zero-extend sub-word loads when 1, sign-extend when 0.
REQ-011 The block SHALL provide ports pc, alu_out and wdata, inputs, DATA_W each: byte addresses and store data (store data right-aligned).
REQ-012 The block SHALL provide ports ir and mdr, outputs, DATA_W each: registered instruction and memory-data registers.
REQ-013 The block SHALL provide port ready, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL provide port err, output, 1 bit: one-cycle pulse, coincident with ready, for a rejected access.
REQ-015 The block SHALL provide port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, BUSY and DONE; busy SHALL be high in BUSY and DONE.
REQ-017 In IDLE with mem_read or mem_write set, the block SHALL latch the selected address, wdata, size, load_unsigned, ir_write and the direction, then enter BUSY with a counter set to LATENCY-1.
REQ-018 BUSY SHALL decrement the counter and exit to DONE when the counter is 0, so that ready rises exactly LATENCY+1 cycles after the request edge.
REQ-019 The word index SHALL be address bits [DEPTH_LOG2+log2(DATA_W/8)-1 : log2(DATA_W/8)]; higher address bits SHALL be ignored, so addresses wrap modulo the array size.
REQ-020 A half-word access with address bit 0 set, a word access with any low offset bit set, or size 11 SHALL be rejected: no array access occurs, ready and err pulse, and ir and mdr hold their values.
REQ-021 mem_read and mem_write both set SHALL be rejected with err, exactly as in REQ-020.
REQ-022 A store SHALL write only the addressed byte lanes (byte enables derived from size and offset), with wdata replicated to those lanes, in the final BUSY cycle.
REQ-023 A load SHALL shift the addressed lanes down, extend them per load_unsigned, and write the result into mdr on the DONE cycle.
REQ-024 If the latched ir_write is set, the load result SHALL also load ir on the DONE cycle.
REQ-025 A store SHALL leave mdr and ir unchanged.
REQ-026 DONE SHALL last one cycle, assert ready, and return to IDLE; a request present during DONE SHALL be ignored.
REQ-027 Request inputs SHALL be ignored while in BUSY or DONE; the latched values SHALL govern the access.
REQ-028 A read SHALL return the array contents before any write in the same access; there are no overlapping accesses.

Reset
REQ-029 While rst_n=0, the state SHALL be IDLE and ir, mdr, ready, err, busy and the counter SHALL be 0, asynchronously.
REQ-030 Reset asserted during BUSY SHALL abort the access; a store not yet committed SHALL NOT modify the array.
REQ-031 Array contents SHALL NOT be cleared by reset.

Structure
REQ-032 Package multicycle_mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and the byte-enable function.
REQ-033 The block SHALL instantiate one sub-module, mem_array: a synchronous single-port RAM of 2^DEPTH_LOG2 x DATA_W with per-byte write enables and registered read.

Verification
REQ-034 Word round trip, LATENCY=1: store 0xDEADBEEF to alu_out=0x10, then load it with i_or_d=1 -> ready 2 cycles after each request, and mdr=0xDEADBEEF.
REQ-035 Byte lanes: with word 0x10 = 0xDEADBEEF, store byte 0x5A at 0x12, then load byte at 0x12 signed and unsigned -> word = 0xDE5ABEEF; mdr = 0x0000005A both times. A signed load of byte 0xDE at 0x13 -> mdr = 0xFFFFFFDE.
REQ-036 Instruction fetch: pc=0x20, i_or_d=0, ir_write=1, word 0x8C220004 -> ir=0x8C220004 and mdr=0x8C220004; the same read with ir_write=0 leaves ir unchanged.
REQ-037 Errors: word load at 0x02, half load at 0x01, size=11, and read+write together -> each produces ready=err=1 for one cycle, with mdr and ir unchanged and memory unchanged.
REQ-038 LATENCY=4 with reset: ready arrives 5 cycles after the request; rst_n pulsed low in the 3rd BUSY cycle of a store of 0x11111111 over 0x22222222 -> outputs 0, the word still reads 0x22222222, and wraparound address 0x800+0x10 aliases word 0x10.
